// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue sequencer states, strobe polarity
// and common ASCII control bytes.
package uart_pkg;

  typedef enum logic [1:0] {TQIdle, TQLoad, TQWaitDone, TQGap} TxQState;

  localparam logic       TX_EN_ACTIVE = 1'b0;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer-side queue signals plus the UARTTx strobe/completion pair.
interface uart_tx_queue_if #(parameter int DEPTH = 8);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          push;
  logic [7:0]    push_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          busy;
  logic          tx_en;
  logic [7:0]    tx_byte;
  logic          tx_complete;

  modport master (
    output push, push_data, tx_complete,
    input  full, empty, level, overflow, busy, tx_en, tx_byte
  );

  modport slave (
    input  push, push_data, tx_complete,
    output full, empty, level, overflow, busy, tx_en, tx_byte
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/level and a sticky overflow flag.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;
  logic             wr;
  logic             rd;

  // full comes from the registered level, so a push while full is dropped
  // even if a pop frees a slot in the same cycle.
  assign wr       = push && !full;
  assign rd       = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({wr, rd})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding UARTTx: one active-low tx_en strobe per queued byte,
// each next byte waits for a tx_complete rising event plus a fixed idle gap.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_queue_if.slave   bus
);

  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  TxQState       state;
  TxQState       state_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_nxt;
  logic          tx_en_nxt;
  logic          pop;
  logic          tx_complete_q;
  logic          rise;
  logic [7:0]    head;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.push),
    .push_data (bus.push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (bus.full),
    .empty     (bus.empty),
    .level     (bus.level),
    .overflow  (bus.overflow)
  );

  // Edge detect works for both a done pulse and an idle-high done level.
  assign rise     = bus.tx_complete && !tx_complete_q;
  assign bus.busy = (state != TQIdle);

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    tx_en_nxt   = ~TX_EN_ACTIVE;
    pop         = 1'b0;
    case (state)
      TQIdle: if (!bus.empty) state_nxt = TQLoad;
      TQLoad: begin
        tx_en_nxt = TX_EN_ACTIVE;
        pop       = 1'b1;
        state_nxt = TQWaitDone;
      end
      TQWaitDone: begin
        if (rise) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = bus.empty ? TQIdle : TQLoad;
          end else begin
            gap_cnt_nxt = GAP_LOAD;
            state_nxt   = TQGap;
          end
        end
      end
      TQGap: begin
        if (gap_cnt == '0) state_nxt = bus.empty ? TQIdle : TQLoad;
        else               gap_cnt_nxt = gap_cnt - GAP_ONE;
      end
      default: state_nxt = TQIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= TQIdle;
      gap_cnt       <= '0;
      bus.tx_en     <= ~TX_EN_ACTIVE;
      bus.tx_byte   <= 8'h00;
      tx_complete_q <= 1'b1;
    end else begin
      state         <= state_nxt;
      gap_cnt       <= gap_cnt_nxt;
      bus.tx_en     <= tx_en_nxt;
      tx_complete_q <= bus.tx_complete;
      if (state == TQLoad) bus.tx_byte <= head;
    end
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue and transmit sequencer that sits directly upstream of the UARTTx serializer.
- Producers (control FSMs, response formatters) push bytes at clock rate.
- The block buffers them in a FIFO and feeds UARTTx one byte at a time using its active-low tx_en strobe, waiting for tx_complete before each next byte.
- Removes the per-byte send/wait sequencing from every client state machine.

Parameters:
- DEPTH, 8, FIFO capacity in bytes; power of two, minimum 2.
- GAP_CYCLES, 2, idle clocks inserted after each tx_complete before the next strobe; 0 = no gap.

Ports:
- clk  input  1  system clock (25 MHz board clock)
- reset  input  1  synchronous, active-high reset
- push  input  1  write push_data into the queue this cycle
- push_data  input  8  byte to enqueue
- full  output  1  queue holds DEPTH bytes
- empty  output  1  queue holds 0 bytes
- level  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: a push was dropped
- busy  output  1  sequencer not in IDLE
- tx_en  output  1  to UARTTx; active-low, one-cycle start strobe
- tx_byte  output  8  to UARTTx; byte to send, held stable until the next strobe
- tx_complete  input  1  from UARTTx; completion indication

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high (clk, reset).
- Reset values:
  - tx_en=1, tx_byte=0x00, full=0, empty=1, level=0, overflow=0, busy=0.
  - FSM=IDLE, FIFO pointers=0, tx_complete_q=1.
- Mid-operation reset: all of the above apply on the next edge. A byte already started in UARTTx is not aborted. Any tx_complete edge from it is ignored because the FSM is in IDLE.
- FIFO rules:
  - Write on push && !full.
  - Push while full is dropped and sets overflow (sticky until reset). This holds even if a pop occurs in the same cycle; full is evaluated on the registered level.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - full, empty and level are registered and consistent with each other every cycle.
- Completion event: rise = tx_complete && !tx_complete_q, where tx_complete_q is tx_complete registered every cycle. This supports both a one-cycle done pulse and a level that is high when idle and low while shifting.
- FSM (TxQState):
  - IDLE: if !empty -> LOAD.
  - LOAD:
    - tx_byte <= FIFO head, tx_en <= 0, pop one entry -> WAIT_DONE.
  - WAIT_DONE:
    - tx_en <= 1, i.e. the strobe is low for exactly one cycle.
    - On rise: if GAP_CYCLES==0, go to LOAD if !empty, else IDLE. Otherwise load gap counter = GAP_CYCLES-1 -> GAP.
    - No timeout.
  - GAP: decrement counter; at 0 -> LOAD if !empty, else IDLE.
  - busy = (state != IDLE).
- Latency:
  - Push sampled at edge E0 into an empty queue with FSM in IDLE: FSM enters LOAD at E1, and tx_en is low in the cycle following E2 with tx_byte valid.
  - First strobe therefore appears two edges after push. Back-to-back bytes are separated by the UART frame time plus GAP_CYCLES+1 clocks.
- Ordering: strict FIFO. Each pushed, non-dropped byte produces exactly one strobe.
- Width rule: level is $clog2(DEPTH)+1 bits so that DEPTH is representable.

Decomposition:
- Shared package uart_pkg:
  - typedef enum TxQState {TQIdle, TQLoad, TQWaitDone, TQGap}.
  - localparam TX_EN_ACTIVE = 1'b0.
  - localparam ASCII_CR = 8'h0D, ASCII_LF = 8'h0A.
- One sub-module is natural: sync_fifo (parameterised WIDTH/DEPTH; push/pop/full/empty/level, synchronous active-high reset), reusable later for an RX queue.

Test Plan:
- Reset: hold reset 3 cycles with push=1 and tx_complete toggling -> tx_en=1, empty=1, level=0, overflow=0, busy=0 throughout and one cycle after release.
- Single byte: push 0x4F at E0; UARTTx model pulses tx_complete 40 cycles after the strobe -> tx_en low exactly one cycle after E2 with tx_byte=0x4F; busy stays 1 until GAP_CYCLES=2 clocks after the pulse, then IDLE.
- Burst: push 0x4F, 0x6B, 0x0D, 0x0A on consecutive cycles -> four strobes in that order; each strobe is ≥3 clocks after the previous completion; level peaks at 3 and ends at 0.
- Overflow (DEPTH=8): push 10 bytes 0x00..0x09 on consecutive cycles with tx_complete held low -> 0x00 popped at LOAD; full after the 9th push; 0x09 dropped; overflow=1 sticky; after completions, 0x00..0x08 are transmitted.
- Level-style completion: tx_complete high at idle, low 30 cycles per byte after the strobe; push 0x31, 0x32 -> exactly two strobes; no false event at reset release.
- Reset mid-WAIT_DONE with 3 bytes queued: assert reset -> level=0, tx_en=1 next edge; a later tx_complete rise produces no strobe.
